// File: rtl/sha256_msg_padder_if.sv
// Handshake bundle for the SHA-256 padder: message words in, padded 512-bit blocks out.
interface sha256_msg_padder_if #(
  parameter int DATA_W = 64,
  parameter int IW     = $clog2(DATA_W) + 1
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              last_word;
  logic [IW-1:0]     last_invalid_bits;
  logic              in_ready;
  logic [511:0]      block_out;
  logic              block_valid;
  logic              block_last;
  logic              block_ready;

  modport master (
    output data_in, data_valid, last_word, last_invalid_bits, block_ready,
    input  in_ready, block_out, block_valid, block_last
  );

  modport slave (
    input  data_in, data_valid, last_word, last_invalid_bits, block_ready,
    output in_ready, block_out, block_valid, block_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs words into 512-bit blocks, appends 0x80, zero fill and
// the 64-bit message bit length, spilling into an extra block when the tail does not fit.
module sha256_msg_padder #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 64
) (
  input logic               clk,
  input logic               rst,
  sha256_msg_padder_if.slave bus
);
  localparam int WPB = 512 / DATA_W;
  localparam int IW  = $clog2(DATA_W) + 1;
  localparam int CW  = $clog2(WPB);

  typedef enum logic [1:0] {FILL, EMIT_DATA, EMIT_PAD, EMIT_LEN} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_PAD, PEND_LEN} pend_t;

  state_t            state_r, state_s;
  pend_t             pend_r, pend_s;
  logic [CW-1:0]     word_cnt_r, word_cnt_s;
  logic [LEN_W-1:0]  bit_len_r, bit_len_s;
  logic [511:0]      buffer_r, buffer_s;
  logic [511:0]      block_out_r, block_out_s;
  logic              block_valid_r, block_valid_s;
  logic              block_last_r, block_last_s;

  logic [IW-1:0]     inv_s;
  logic [9:0]        valid_bits_s, add_bits_s, slot_base_s, end_pos_s;
  logic [DATA_W-1:0] word_mask_s;
  logic [511:0]      slot_word_s, marked_s;
  logic [LEN_W-1:0]  len_sum_s;

  // Sub-byte invalid counts are meaningless, so only whole bytes are honoured.
  assign inv_s        = bus.last_invalid_bits & ~IW'(7);
  assign valid_bits_s = 10'(DATA_W) - 10'(inv_s);
  assign add_bits_s   = bus.last_word ? valid_bits_s : 10'(DATA_W);
  assign word_mask_s  = bus.last_word ? ({DATA_W{1'b1}} << inv_s) : {DATA_W{1'b1}};
  assign slot_base_s  = 10'(word_cnt_r) * 10'(DATA_W);
  assign slot_word_s  = {bus.data_in & word_mask_s, {(512-DATA_W){1'b0}}} >> slot_base_s;
  assign end_pos_s    = slot_base_s + valid_bits_s;
  // A shift of 512 drops the marker entirely, which is exactly the deferred-0x80 case.
  assign marked_s     = buffer_r | slot_word_s | ({8'h80, 504'h0} >> end_pos_s);
  assign len_sum_s    = bit_len_r + LEN_W'(add_bits_s);

  assign bus.in_ready    = (state_r == FILL);
  assign bus.block_out   = block_out_r;
  assign bus.block_valid = block_valid_r;
  assign bus.block_last  = block_last_r;

  // Next-state and next-output logic for fill/emit sequencing.
  always_comb begin
    state_s       = state_r;
    pend_s        = pend_r;
    word_cnt_s    = word_cnt_r;
    bit_len_s     = bit_len_r;
    buffer_s      = buffer_r;
    block_out_s   = block_out_r;
    block_valid_s = block_valid_r;
    block_last_s  = block_last_r;
    case (state_r)
      FILL: begin
        if (bus.data_valid) begin
          word_cnt_s    = word_cnt_r + CW'(1);
          bit_len_s     = len_sum_s;
          buffer_s      = marked_s;
          block_out_s   = marked_s;
          block_valid_s = 1'b1;
          block_last_s  = 1'b0;
          pend_s        = PEND_NONE;
          if (!bus.last_word) begin
            buffer_s    = buffer_r | slot_word_s;
            block_out_s = buffer_r | slot_word_s;
            if (word_cnt_r == CW'(WPB-1)) begin
              state_s = EMIT_DATA;
            end else begin
              block_valid_s = 1'b0;
              block_out_s   = block_out_r;
            end
          end else if (end_pos_s == 10'd512) begin
            state_s = EMIT_DATA;
            pend_s  = PEND_PAD;
          end else if (end_pos_s <= 10'd440) begin
            state_s      = EMIT_LEN;
            block_out_s  = {marked_s[511:LEN_W], len_sum_s};
            block_last_s = 1'b1;
          end else begin
            state_s = EMIT_DATA;
            pend_s  = PEND_LEN;
          end
        end else begin
          state_s = FILL;
        end
      end
      default: begin
        if (bus.block_ready) begin
          pend_s = PEND_NONE;
          case (pend_r)
            PEND_PAD: begin
              state_s      = EMIT_PAD;
              block_out_s  = {8'h80, {(504-LEN_W){1'b0}}, bit_len_r};
              block_last_s = 1'b1;
            end
            PEND_LEN: begin
              state_s      = EMIT_LEN;
              block_out_s  = {{(512-LEN_W){1'b0}}, bit_len_r};
              block_last_s = 1'b1;
            end
            default: begin
              state_s       = FILL;
              buffer_s      = 512'h0;
              block_valid_s = 1'b0;
              block_last_s  = 1'b0;
              if (block_last_r) begin
                bit_len_s  = {LEN_W{1'b0}};
                word_cnt_s = {CW{1'b0}};
              end else begin
                bit_len_s  = bit_len_r;
              end
            end
          endcase
        end else begin
          state_s = state_r;
        end
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FILL;
      pend_r        <= PEND_NONE;
      word_cnt_r    <= {CW{1'b0}};
      bit_len_r     <= {LEN_W{1'b0}};
      buffer_r      <= 512'h0;
      block_out_r   <= 512'h0;
      block_valid_r <= 1'b0;
      block_last_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      pend_r        <= pend_s;
      word_cnt_r    <= word_cnt_s;
      bit_len_r     <= bit_len_s;
      buffer_r      <= buffer_s;
      block_out_r   <= block_out_s;
      block_valid_r <= block_valid_s;
      block_last_r  <= block_last_s;
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder at DATA_W 32/64/128; expected blocks are hand-derived.
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int           cur_w = 64;
  logic [127:0] din   = 128'h0;
  logic         dv    = 1'b0;
  logic         lw    = 1'b0;
  logic [7:0]   linv  = 8'h0;
  logic         brdy  = 1'b0;
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   msg [0:127];

  localparam logic [511:0] ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY = {8'h80, 440'h0, 64'h0};

  sha256_msg_padder_if #(.DATA_W(32))  i32 ();
  sha256_msg_padder_if #(.DATA_W(64))  i64 ();
  sha256_msg_padder_if #(.DATA_W(128)) i128 ();

  assign i32.data_in            = din[31:0];
  assign i32.data_valid         = dv && (cur_w == 32);
  assign i32.last_word          = lw;
  assign i32.last_invalid_bits  = linv[5:0];
  assign i32.block_ready        = brdy && (cur_w == 32);
  assign i64.data_in            = din[63:0];
  assign i64.data_valid         = dv && (cur_w == 64);
  assign i64.last_word          = lw;
  assign i64.last_invalid_bits  = linv[6:0];
  assign i64.block_ready        = brdy && (cur_w == 64);
  assign i128.data_in           = din;
  assign i128.data_valid        = dv && (cur_w == 128);
  assign i128.last_word         = lw;
  assign i128.last_invalid_bits = linv;
  assign i128.block_ready       = brdy && (cur_w == 128);

  sha256_msg_padder #(.DATA_W(32))  u32  (.clk(clk), .rst(rst), .bus(i32.slave));
  sha256_msg_padder #(.DATA_W(64))  u64  (.clk(clk), .rst(rst), .bus(i64.slave));
  sha256_msg_padder #(.DATA_W(128)) u128 (.clk(clk), .rst(rst), .bus(i128.slave));

  logic [511:0] bo;
  logic         bv, bl, ir;
  // Route the currently selected instance to the shared observation signals.
  always_comb begin
    case (cur_w)
      32:      begin bo = i32.block_out;  bv = i32.block_valid;  bl = i32.block_last;  ir = i32.in_ready;  end
      128:     begin bo = i128.block_out; bv = i128.block_valid; bl = i128.block_last; ir = i128.in_ready; end
      default: begin bo = i64.block_out;  bv = i64.block_valid;  bl = i64.block_last;  ir = i64.in_ready;  end
    endcase
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send(input logic [127:0] d, input logic l, input logic [7:0] inv);
    int n = 0;
    while (!ir && n < 50) begin @(negedge clk); n++; end
    chk("send_in_ready", ir, 1'b1);
    din = d; dv = 1'b1; lw = l; linv = inv;
    @(negedge clk);
    dv = 1'b0; lw = 1'b0; linv = 8'hff; din = {128{1'b1}};
  endtask

  task automatic recv(input string tag, input logic [511:0] eb, input logic el);
    int n = 0;
    while (!bv && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, bv, 1'b1);
    chk({tag, "_block"}, bo, eb);
    chk({tag, "_last"}, bl, el);
    chk({tag, "_in_ready"}, ir, 1'b0);
    brdy = 1'b1;
    @(negedge clk);
    brdy = 1'b0;
  endtask

  // 64-bit words from msg[]; gap_at inserts a 10-cycle idle with stray last_word noise.
  task automatic send_words(input int nbytes, input int w_from, input int w_to, input int gap_at);
    int nw = (nbytes + 7) / 8;
    for (int w = w_from; w <= w_to; w++) begin
      logic [127:0] d;
      int vb;
      d = 128'h0; vb = 0;
      for (int b = 0; b < 8; b++) begin
        if (w * 8 + b < nbytes) begin d[63 - 8*b -: 8] = msg[w*8 + b]; vb++; end
      end
      if (w == gap_at) begin
        repeat (10) begin lw = 1'b1; linv = 8'($urandom); @(negedge clk); end
        lw = 1'b0;
      end
      send(d, (w == nw - 1), 8'((8 - vb) * 8));
    end
  endtask

  logic [511:0] e1;

  initial begin
    repeat (3) @(negedge clk);
    for (int w = 32; w <= 128; w = w * 2) begin
      cur_w = w;
      #0;
      chk("rst_in_ready", ir, 1'b1);
      chk("rst_valid", bv, 1'b0);
      chk("rst_block", bo, 512'h0);
      chk("rst_last", bl, 1'b0);
    end
    cur_w = 64;
    rst = 1'b0;
    @(negedge clk);

    send(128'h6162630000000000, 1'b1, 8'd40);
    chk("abc_latency", bv, 1'b1);
    recv("abc64", ABC, 1'b1);
    chk("abc_back_to_fill", ir, 1'b1);

    send(128'h0, 1'b1, 8'd64);
    recv("empty", EMPTY, 1'b1);

    for (int i = 0; i < 56; i++) msg[i] = 8'(8'h30 + (i + 1) % 10);
    e1 = 512'h0;
    for (int i = 0; i < 56; i++) e1[511 - 8*i -: 8] = msg[i];
    e1[511 - 8*56 -: 8] = 8'h80;
    send_words(56, 0, 6, -1);
    recv("m56_b1", e1, 1'b0);
    recv("m56_b2", {448'h0, 64'h1C0}, 1'b1);
    send_words(56, 0, 6, 3);
    recv("gap_b1", e1, 1'b0);
    recv("gap_b2", {448'h0, 64'h1C0}, 1'b1);

    for (int i = 0; i < 64; i++) msg[i] = 8'(i * 3 + 1);
    for (int i = 0; i < 64; i++) e1[511 - 8*i -: 8] = msg[i];
    send_words(64, 0, 7, -1);
    recv("m64_b1", e1, 1'b0);
    recv("m64_b2", {8'h80, 440'h0, 64'h200}, 1'b1);

    for (int i = 0; i < 72; i++) msg[i] = 8'(255 - i);
    for (int i = 0; i < 64; i++) e1[511 - 8*i -: 8] = msg[i];
    send_words(72, 0, 7, -1);
    recv("m72_b1", e1, 1'b0);
    chk("m72_refill_ready", ir, 1'b1);
    send_words(72, 8, 8, -1);
    e1 = 512'h0;
    for (int i = 0; i < 8; i++) e1[511 - 8*i -: 8] = msg[64 + i];
    e1[447:440] = 8'h80;
    e1[63:0] = 64'h240;
    recv("m72_b2", e1, 1'b1);

    send(128'h6162630000000000, 1'b1, 8'd40);
    for (int c = 0; c < 5; c++) begin
      chk("stall_block", bo, ABC);
      chk("stall_in_ready", ir, 1'b0);
      chk("stall_valid", bv, 1'b1);
      @(negedge clk);
    end
    recv("stall", ABC, 1'b1);

    send_words(64, 0, 2, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", ir, 1'b1);
    chk("mid_rst_valid", bv, 1'b0);
    chk("mid_rst_block", bo, 512'h0);
    send(128'h6162630000000000, 1'b1, 8'd40);
    recv("post_rst_abc", ABC, 1'b1);

    send(128'h6162630000000000, 1'b1, 8'd40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("emit_rst_valid", bv, 1'b0);
    chk("emit_rst_in_ready", ir, 1'b1);
    send(128'h0, 1'b1, 8'd64);
    recv("post_emit_rst", EMPTY, 1'b1);

    cur_w = 32;
    @(negedge clk);
    send(128'h61626300, 1'b1, 8'd8);
    recv("abc32", ABC, 1'b1);

    cur_w = 128;
    @(negedge clk);
    send(128'h6162_6300_0000_0000_0000_0000_0000_0000, 1'b1, 8'd104);
    recv("abc128", ABC, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 Parameter DATA_W, default 64: input word width in bits; legal values 32, 64, 128.
REQ-002 Parameter LEN_W, default 64: message bit-length counter width; fixed at 64 for SHA-256 compliance.
REQ-003 Derived constant WPB = 512/DATA_W: words per block. Derived constant IW = $clog2(DATA_W)+1: width of the invalid-bits count.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 data_in  in  DATA_W  message word; first message byte in bits [DATA_W-1:DATA_W-8].
REQ-007 data_valid  in  1  data_in valid; a word transfers on a cycle with data_valid && in_ready.
REQ-008 last_word  in  1  qualifies the transferring word as the final word of the message.
REQ-009 last_invalid_bits  in  IW  count of trailing invalid bits in the final word; meaningful only with last_word.
REQ-010 in_ready  out  1  padder can accept a word this cycle.
REQ-011 block_out  out  512  padded 512-bit SHA-256 block, MSB-first.
REQ-012 block_valid  out  1  block_out is valid.
REQ-013 block_last  out  1  block_out is the final block of the message; qualified by block_valid.
REQ-014 block_ready  in  1  downstream accepts a block on a cycle with block_valid && block_ready.

Function
REQ-015 FSM states: FILL, EMIT_DATA, EMIT_PAD, EMIT_LEN. in_ready = 1 only in FILL.
REQ-016 FILL: each transferred word is written into buffer slot word_cnt (slot 0 = bits [511:512-DATA_W]); word_cnt increments; bit_len increases by DATA_W - last_invalid_bits on the last word, DATA_W otherwise.
REQ-017 last_invalid_bits is byte-granular: bits [2:0] are ignored; legal values 0..DATA_W; DATA_W on a last word denotes zero valid bytes (empty message or empty tail).
REQ-018 Non-last word filling slot WPB-1 -> EMIT_DATA with block_last = 0; word_cnt wraps to 0.
REQ-019 Last word with valid bytes: invalid bytes are zeroed and 0x80 is written at the first invalid byte position. If that word fills slot WPB-1 with no invalid bytes, the 0x80 is not written; go to EMIT_DATA, then EMIT_PAD.
REQ-020 On the last word, let P = bit position after 0x80 (or after the last valid byte when 0x80 is deferred). If P <= 448: zero bits up to 448, place bit_len in bits [63:0], go to EMIT_LEN with block_last = 1. Otherwise zero the remainder of the block and go to EMIT_DATA with block_last = 0, then EMIT_LEN.
REQ-021 EMIT_PAD block: 0x80 in bits [511:504], zeros, bit_len in [63:0], block_last = 1.
REQ-022 EMIT_LEN block in the spill case: all zeros except bit_len in [63:0], block_last = 1.
REQ-023 block_valid rises the cycle after the transfer that completes a block; block_out and block_last are held stable while block_valid && !block_ready.
REQ-024 On a block handshake: next pending block -> next EMIT state the following cycle; otherwise -> FILL, with buffer cleared. After the final block, bit_len and word_cnt also clear.
REQ-025 Throughput: one in_ready-low cycle minimum per emitted block; no input is accepted while any block is pending.
REQ-026 bit_len wraps modulo 2^64; no error flag.
REQ-027 data_valid may drop between words for any number of cycles with no effect on state.
REQ-028 last_word without data_valid, and last_word/last_invalid_bits on non-transfer cycles, are ignored.

Reset
REQ-029 rst high at any rising edge, including mid-message or mid-emit, forces the following state: FILL; word_cnt = 0; bit_len = 0; buffer = 0; block_valid = 0; block_last = 0; block_out = 0; in_ready = 1.
REQ-030 A partially transferred message is discarded on reset; no block is emitted for it.

Verification
REQ-031 DATA_W=64, "abc": data_in=0x6162630000000000, last_word, invalid=40 -> one block 0x61626380, zeros, [63:0]=0x18, block_last=1.
REQ-032 Empty message: last_word, invalid=64 -> one block 0x80 followed by zeros, [63:0]=0, block_last=1.
REQ-033 56 bytes of "1234567890...": two blocks. Block 1: data, 0x80 at byte 56, block_last=0. Block 2: zeros, [63:0]=0x1C0, block_last=1.
REQ-034 64-byte message, invalid=0 on word 8: two blocks. Block 1 = raw data, block_last=0. Block 2 = 0x80, zeros, [63:0]=0x200, block_last=1.
REQ-035 block_ready held low 5 cycles while block_valid is high -> block_out stable and in_ready=0 throughout. Also: data_valid gap of 10 cycles mid-message -> output identical to the gapless run.
REQ-036 DATA_W=32 and DATA_W=128, "abc" -> same block as REQ-031. Also: rst asserted after 3 words -> next cycle in_ready=1, block_valid=0, and a following "abc" hashes correctly.
